traffic_phase_sequencer: RTL and testbench

//  Parametrised N-phase traffic-light sequencer; successor to the fixed 3-mode controller.

---
 rtl/traffic_pkg.sv | 18 +
 rtl/traffic_down_timer.sv | 32 +++
 rtl/traffic_phase_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_traffic_phase_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg: shared types for the traffic phase sequencer.
//   state_t    - 3-bit controller state encoding (S_FLASH kept reserved when flashing is not built)
//   lamp_vec_t - lamp vector wide enough for the largest supported junction
package traffic_pkg;

    localparam int unsigned MAX_PHASES = 8;

    typedef enum logic [2:0] {
        S_ALLRED = 3'd0,
        S_GREEN  = 3'd1,
        S_YELLOW = 3'd2,
        S_WALK   = 3'd3,
        S_FLASH  = 3'd4
    } state_t;

    typedef logic [MAX_PHASES-1:0] lamp_vec_t;

endpackage

// File: rtl/traffic_down_timer.sv
// traffic_down_timer: loadable TW-bit down-counter with a zero flag.
//   clk, rst_n  - clock, asynchronous active-low reset (count resets to RST_VAL)
//   i_load      - load i_load_val this edge (takes priority over decrement)
//   i_load_val  - value to load
//   o_zero_c    - combinational: count is zero
module traffic_down_timer #(
    parameter int unsigned TW      = 8,
    parameter int unsigned RST_VAL = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic [TW-1:0] i_load_val,
    output logic          o_zero_c
);

    logic [TW-1:0] r_count;

    // Count down and park at zero until the owner reloads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= TW'(RST_VAL);
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - TW'(1);
        end
    end

    assign o_zero_c = (r_count == '0);

endmodule

// File: rtl/traffic_phase_sequencer.sv
// traffic_phase_sequencer: N-phase green/yellow/all-red sequencer with a latched
// pedestrian WALK interval and optional flashing-yellow mode.
//   clk        - clock, rising edge
//   reset      - asynchronous active-low reset
//   green_time - per-phase green duration, field i = [i*TW +: TW]; 0 skips the phase
//   ped_req    - pedestrian request, level sampled every cycle
//   flash_mode - flashing-yellow request (only when TRAFFIC_FLASH_EN is defined)
//   green/yellow/red - registered per-phase lamps
//   walk       - registered pedestrian lamp
//   phase_idx  - current or last-served phase
// Build option: define TRAFFIC_FLASH_EN to add flash_mode and the S_FLASH behaviour.
module traffic_phase_sequencer
    import traffic_pkg::*;
#(
    parameter int unsigned NUM_PHASES   = 3,
    parameter int unsigned TW           = 8,
    parameter int unsigned YELLOW_TICKS = 2,
    parameter int unsigned ALLRED_TICKS = 1,
    parameter int unsigned WALK_TICKS   = 6,
    parameter int unsigned FLASH_TICKS  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_PHASES*TW-1:0]      green_time,
    input  logic                          ped_req,
`ifdef TRAFFIC_FLASH_EN
    input  logic                          flash_mode,
`endif
    output logic [NUM_PHASES-1:0]         green,
    output logic [NUM_PHASES-1:0]         yellow,
    output logic [NUM_PHASES-1:0]         red,
    output logic                          walk,
    output logic [$clog2(NUM_PHASES)-1:0] phase_idx
);

    localparam int unsigned PW = $clog2(NUM_PHASES);

    state_t                r_state;
    logic [PW-1:0]         r_phase;
    logic                  r_ped;
    logic                  r_flash_on;
    logic [NUM_PHASES-1:0] r_green;
    logic [NUM_PHASES-1:0] r_yellow;
    logic [NUM_PHASES-1:0] r_red;
    logic                  r_walk;

    logic                  w_flash_req;
    logic                  w_timer_zero;
    logic [TW-1:0]         w_load_val;
    logic [TW-1:0]         w_gt [NUM_PHASES];
    logic                  w_found;
    logic [PW-1:0]         w_scan_idx;
    logic [PW-1:0]         w_cand;
    state_t                w_next_state;
    logic [PW-1:0]         w_next_phase;
    logic                  w_next_ped;
    logic                  w_next_flash_on;
    lamp_vec_t             w_onehot;
    logic [NUM_PHASES-1:0] w_green_n;
    logic [NUM_PHASES-1:0] w_yellow_n;
    logic [NUM_PHASES-1:0] w_red_n;
    logic                  w_walk_n;

`ifdef TRAFFIC_FLASH_EN
    assign w_flash_req = flash_mode;
`else
    assign w_flash_req = 1'b0;
`endif

    // Interval timer; reloaded on every edge where it reaches zero.
    traffic_down_timer #(
        .TW      (TW),
        .RST_VAL (ALLRED_TICKS - 1)
    ) u_timer (
        .clk        (clk),
        .rst_n      (reset),
        .i_load     (w_timer_zero),
        .i_load_val (w_load_val),
        .o_zero_c   (w_timer_zero)
    );

    // Unpack the per-phase green durations.
    always_comb begin
        for (int i = 0; i < int'(NUM_PHASES); i++) begin
            w_gt[i] = green_time[i*TW +: TW];
        end
    end

    // Priority scan: first enabled phase after r_phase (wrapping); nearest wins, so scan far-to-near.
    always_comb begin
        w_found    = 1'b0;
        w_scan_idx = r_phase;
        w_cand     = '0;
        for (int k = int'(NUM_PHASES); k >= 1; k--) begin
            w_cand = PW'((int'(r_phase) + k) % int'(NUM_PHASES));
            if (w_gt[w_cand] != '0) begin
                w_found    = 1'b1;
                w_scan_idx = w_cand;
            end
        end
    end

    // Next-state and timer reload logic.
    always_comb begin
        w_next_state    = r_state;
        w_next_phase    = r_phase;
        w_next_ped      = r_ped | (ped_req & (r_state != S_WALK));
        w_next_flash_on = r_flash_on;
        w_load_val      = TW'(ALLRED_TICKS - 1);
        if (w_timer_zero) begin
            case (r_state)
                S_ALLRED: begin
                    if (w_flash_req) begin
                        w_next_state    = S_FLASH;
                        w_next_flash_on = 1'b1;
                        w_load_val      = TW'(FLASH_TICKS - 1);
                    end else if (r_ped) begin
                        w_next_state = S_WALK;
                        w_next_ped   = 1'b0;
                        w_load_val   = TW'(WALK_TICKS - 1);
                    end else if (w_found) begin
                        w_next_state = S_GREEN;
                        w_next_phase = w_scan_idx;
                        w_load_val   = w_gt[w_scan_idx] - TW'(1);
                    end
                end
                S_GREEN: begin
                    w_next_state = S_YELLOW;
                    w_load_val   = TW'(YELLOW_TICKS - 1);
                end
                S_YELLOW, S_WALK: begin
                    w_next_state = S_ALLRED;
                end
                S_FLASH: begin
                    if (!w_flash_req) begin
                        // Park on the last phase so the scan restarts at phase 0.
                        w_next_state    = S_ALLRED;
                        w_next_phase    = PW'(NUM_PHASES - 1);
                        w_next_flash_on = 1'b0;
                    end else begin
                        w_next_flash_on = ~r_flash_on;
                        w_load_val      = TW'(FLASH_TICKS - 1);
                    end
                end
                default: begin
                    w_next_state = S_ALLRED;
                end
            endcase
        end
    end

    // Moore lamp decode of the next state so the lamp registers track the state register.
    always_comb begin
        w_onehot   = lamp_vec_t'(1) << w_next_phase;
        w_green_n  = '0;
        w_yellow_n = '0;
        w_walk_n   = 1'b0;
        case (w_next_state)
            S_GREEN:  w_green_n  = w_onehot[NUM_PHASES-1:0];
            S_YELLOW: w_yellow_n = w_onehot[NUM_PHASES-1:0];
            S_FLASH:  w_yellow_n = {NUM_PHASES{w_next_flash_on}};
            S_WALK:   w_walk_n   = 1'b1;
            default:  ;
        endcase
        w_red_n = (w_next_state == S_FLASH) ? '0 : ~(w_green_n | w_yellow_n);
    end

    // State and registered lamp outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_ALLRED;
            r_phase    <= PW'(NUM_PHASES - 1);
            r_ped      <= 1'b0;
            r_flash_on <= 1'b0;
            r_green    <= '0;
            r_yellow   <= '0;
            r_red      <= '1;
            r_walk     <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_phase    <= w_next_phase;
            r_ped      <= w_next_ped;
            r_flash_on <= w_next_flash_on;
            r_green    <= w_green_n;
            r_yellow   <= w_yellow_n;
            r_red      <= w_red_n;
            r_walk     <= w_walk_n;
        end
    end

    assign green     = r_green;
    assign yellow    = r_yellow;
    assign red       = r_red;
    assign walk      = r_walk;
    assign phase_idx = r_phase;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Bench for traffic_phase_sequencer: directed table, hand sequences for the
// multi-cycle corner cases, and random traffic against an interval-level model.
module tb_traffic_phase_sequencer;

    localparam int NP = 3;
    localparam int TW = 8;
    localparam int YT = 2;
    localparam int AT = 1;
    localparam int WT = 6;
    localparam int FT = 4;
    localparam int ALL = (1 << NP) - 1;

`ifdef TRAFFIC_FLASH_EN
    localparam bit FLASH_EN = 1'b1;
`else
    localparam bit FLASH_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NP*TW-1:0]  green_time;
    logic              ped_req = 1'b0;
    logic              flash_mode = 1'b0;
    logic [NP-1:0]     green, yellow, red;
    logic              walk;
    logic [1:0]        phase_idx;

    always #5 clk = ~clk;

    traffic_phase_sequencer #(
        .NUM_PHASES   (NP),
        .TW           (TW),
        .YELLOW_TICKS (YT),
        .ALLRED_TICKS (AT),
        .WALK_TICKS   (WT),
        .FLASH_TICKS  (FT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .green_time (green_time),
        .ped_req    (ped_req),
`ifdef TRAFFIC_FLASH_EN
        .flash_mode (flash_mode),
`endif
        .green      (green),
        .yellow     (yellow),
        .red        (red),
        .walk       (walk),
        .phase_idx  (phase_idx)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    // Interval model: kind 0=all-red 1=green 2=yellow 3=walk 4=flash; m_left = cycles remaining.
    int m_kind, m_ph, m_left;
    bit m_ped, m_flon;

    function automatic int gt_of(input int p);
        return int'(green_time[p*TW +: TW]);
    endfunction

    task automatic model_reset();
        m_kind = 0; m_ph = NP - 1; m_left = AT; m_ped = 1'b0; m_flon = 1'b0;
    endtask

    task automatic model_step();
        bit np;
        int pick;
        np = m_ped | (ped_req && m_kind != 3);
        m_left--;
        if (m_left == 0) begin
            case (m_kind)
                0: begin
                    if (FLASH_EN && flash_mode) begin
                        m_kind = 4; m_flon = 1'b1; m_left = FT;
                    end else if (m_ped) begin
                        m_kind = 3; m_left = WT; np = 1'b0;
                    end else begin
                        pick = -1;
                        for (int k = 1; k <= NP; k++)
                            if (pick < 0 && gt_of((m_ph + k) % NP) != 0) pick = (m_ph + k) % NP;
                        if (pick >= 0) begin
                            m_kind = 1; m_ph = pick; m_left = gt_of(pick);
                        end else begin
                            m_left = AT;
                        end
                    end
                end
                1: begin m_kind = 2; m_left = YT; end
                2, 3: begin m_kind = 0; m_left = AT; end
                default: begin
                    if (!flash_mode) begin
                        m_kind = 0; m_left = AT; m_ph = NP - 1; m_flon = 1'b0;
                    end else begin
                        m_flon = !m_flon; m_left = FT;
                    end
                end
            endcase
        end
        m_ped = np;
    endtask

    task automatic cmp_model();
        int eg, ey, er;
        eg = (m_kind == 1) ? (1 << m_ph) : 0;
        ey = (m_kind == 2) ? (1 << m_ph) : ((m_kind == 4 && m_flon) ? ALL : 0);
        er = (m_kind == 4) ? 0 : (~(eg | ey) & ALL);
        chk("model_green",  int'(green),     eg);
        chk("model_yellow", int'(yellow),    ey);
        chk("model_red",    int'(red),       er);
        chk("model_walk",   int'(walk),      int'(m_kind == 3));
        chk("model_phase",  int'(phase_idx), m_ph);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        cmp_model();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        chk("rst_red",    int'(red),       ALL);
        chk("rst_green",  int'(green),     0);
        chk("rst_yellow", int'(yellow),    0);
        chk("rst_walk",   int'(walk),      0);
        chk("rst_phase",  int'(phase_idx), NP - 1);
        reset = 1'b1;
    endtask

    typedef struct {
        int         n;
        logic       ped;
        logic [2:0] g, y, r;
        logic       w;
        int         ph;
    } vec_t;

    vec_t tbl[10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int wc, prev, tot;
        int wtr[32];
        int grn[32];
        int seq[$];

        tbl[0] = '{4, 1'b0, 3'b001, 3'b000, 3'b110, 1'b0, 0};
        tbl[1] = '{2, 1'b0, 3'b000, 3'b001, 3'b110, 1'b0, 0};
        tbl[2] = '{1, 1'b0, 3'b000, 3'b000, 3'b111, 1'b0, 0};
        tbl[3] = '{3, 1'b0, 3'b010, 3'b000, 3'b101, 1'b0, 1};
        tbl[4] = '{2, 1'b0, 3'b000, 3'b010, 3'b101, 1'b0, 1};
        tbl[5] = '{1, 1'b0, 3'b000, 3'b000, 3'b111, 1'b0, 1};
        tbl[6] = '{5, 1'b0, 3'b100, 3'b000, 3'b011, 1'b0, 2};
        tbl[7] = '{2, 1'b0, 3'b000, 3'b100, 3'b011, 1'b0, 2};
        tbl[8] = '{1, 1'b0, 3'b000, 3'b000, 3'b111, 1'b0, 2};
        tbl[9] = '{1, 1'b0, 3'b001, 3'b000, 3'b110, 1'b0, 0};

        green_time = {8'd5, 8'd3, 8'd4};

        // Basic rotation from reset.
        do_reset();
        chk("t1_red_after_release", int'(red), ALL);
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < tbl[i].n; c++) begin
                ped_req = tbl[i].ped;
                @(posedge clk);
                model_step();
                #1;
                chk("t1_green",  int'(green),     int'(tbl[i].g));
                chk("t1_yellow", int'(yellow),    int'(tbl[i].y));
                chk("t1_red",    int'(red),       int'(tbl[i].r));
                chk("t1_walk",   int'(walk),      int'(tbl[i].w));
                chk("t1_phase",  int'(phase_idx), tbl[i].ph);
            end
        end

        // One-cycle pedestrian pulse during green[0].
        do_reset();
        cycle();
        ped_req = 1'b1;
        cycle();
        ped_req = 1'b0;
        repeat (5) cycle();
        chk("t2_red_before_walk", int'(red), ALL);
        chk("t2_no_walk_yet", int'(walk), 0);
        wc = 0;
        for (int i = 0; i < 7; i++) begin
            cycle();
            if (i == 0) chk("t2_walk_start", int'(walk), 1);
            if (walk) wc++;
            chk("t2_red_in_walk", int'(red), ALL);
        end
        chk("t2_walk_len", wc, WT);
        chk("t2_walk_ended", int'(walk), 0);
        cycle();
        chk("t2_green1_after", int'(green), 3'b010);

        // Request held through a whole walk interval.
        do_reset();
        ped_req = 1'b1;
        for (int e = 1; e <= 27; e++) begin
            cycle();
            wtr[e] = int'(walk);
            grn[e] = int'(green);
            if (e == 15) ped_req = 1'b0;
        end
        wc = 0;
        tot = 0;
        for (int e = 8; e <= 14; e++) wc += wtr[e];
        for (int e = 1; e <= 27; e++) tot += wtr[e];
        chk("t3_first_walk_len", wc, WT);
        chk("t3_green1", grn[15], 3'b010);
        chk("t3_allred_before_2nd", wtr[20], 0);
        chk("t3_second_walk", wtr[21], 1);
        chk("t3_total_walk", tot, 2 * WT);

        // Disabled phase 1 is skipped.
        green_time = {8'd5, 8'd0, 8'd4};
        do_reset();
        prev = 0;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (green != 0 && int'(green) != prev) seq.push_back(int'(green));
            prev = int'(green);
        end
        chk("t4_seq_len_ok", int'(seq.size() >= 3), 1);
        if (seq.size() >= 3) begin
            chk("t4_seq0", seq[0], 3'b001);
            chk("t4_seq1", seq[1], 3'b100);
            chk("t4_seq2", seq[2], 3'b001);
        end

        // All phases disabled: stay all-red, phase constant.
        green_time = '0;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            cycle();
            chk("t4_allzero_red", int'(red), ALL);
            chk("t4_allzero_phase", int'(phase_idx), NP - 1);
        end

        // Reset in the middle of yellow[1].
        green_time = {8'd5, 8'd3, 8'd4};
        do_reset();
        repeat (11) cycle();
        chk("t5_in_yellow1", int'(yellow), 3'b010);
        reset = 1'b0;
        #1;
        chk("t5_red_now", int'(red), ALL);
        chk("t5_yellow_now", int'(yellow), 0);
        chk("t5_green_now", int'(green), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("t5_red_held", int'(red), ALL);
        reset = 1'b1;
        model_reset();
        #1;
        chk("t5_red_after_release", int'(red), ALL);
        cycle();
        chk("t5_green0", int'(green), 3'b001);

`ifdef TRAFFIC_FLASH_EN
        // Flashing-yellow entry and exit.
        do_reset();
        flash_mode = 1'b0;
        repeat (14) cycle();
        chk("t6_green2", int'(green), 3'b100);
        flash_mode = 1'b1;
        repeat (7) cycle();
        chk("t6_allred", int'(red), ALL);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("t6_flash_on", int'(yellow), ALL);
            chk("t6_flash_red", int'(red), 0);
        end
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("t6_flash_off", int'(yellow), 0);
            if (i == 0) flash_mode = 1'b0;
        end
        cycle();
        chk("t6_exit_allred", int'(red), ALL);
        cycle();
        chk("t6_green0", int'(green), 3'b001);
`endif

        // Random traffic against the model.
        flash_mode = 1'b0;
        for (int blk = 0; blk < 40; blk++) begin
            for (int p = 0; p < NP; p++)
                green_time[p*TW +: TW] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 6));
            if ($urandom_range(0, 9) == 0) do_reset();
            for (int c = 0; c < 50; c++) begin
                ped_req = ($urandom_range(0, 9) == 0);
                if ($urandom_range(0, 29) == 0) flash_mode = !flash_mode;
                cycle();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
